// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide engine with architectural HI/LO registers.
// Optional MDU_ZERO_BYPASS_EN skips the iterations for trivially-zero results.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  // state | meaning
  // IDLE  | accepts Start / HiWrite / LoWrite; Done pulses here
  // RUN   | one radix-2 step per cycle while cnt != 0; cnt == 0 moves to FIX
  // FIX   | sign correction, Hi/Lo written, Done raised on exit
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, mq_q, opnd_q, hi_q, lo_q;
  logic             is_div_q, neg_p_q, neg_r_q, raw_q, dz_q;
  logic             busy_q, done_q, divzero_q;

  logic             a_neg, b_neg, div_zero, zero_skip;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] fix_hi_d, fix_lo_d;

  assign a_neg    = ~Op[0] & A[WIDTH-1];
  assign b_neg    = ~Op[0] & B[WIDTH-1];
  assign a_mag    = a_neg ? -A : A;
  assign b_mag    = b_neg ? -B : B;
  assign div_zero = Op[1] & (B == '0);

`ifdef MDU_ZERO_BYPASS_EN
  assign zero_skip = Op[1] ? ((A == '0) && (B != '0)) : ((A == '0) || (B == '0));
`else
  assign zero_skip = 1'b0;
`endif

  // Multiply: acc:mq shifts right with the partial sum; divide: acc:mq shifts left.
  assign mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_sh  = {acc_q, mq_q[WIDTH-1]};
  assign div_ge  = (rem_sh >= {1'b0, opnd_q});
  assign rem_sub = rem_sh[WIDTH-1:0] - opnd_q;

  assign prod     = {acc_q, mq_q};
  assign prod_fix = neg_p_q ? -prod : prod;

  always_comb begin
    fix_hi_d = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo_d = prod_fix[WIDTH-1:0];
    if (raw_q) begin
      fix_hi_d = acc_q;
      fix_lo_d = mq_q;
    end else if (is_div_q) begin
      fix_hi_d = neg_r_q ? -acc_q : acc_q;
      fix_lo_d = neg_p_q ? -mq_q : mq_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_p_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      raw_q     <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_q == S_RUN);
      case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_q   <= S_RUN;
            divzero_q <= 1'b0;
            is_div_q  <= Op[1];
            neg_p_q   <= a_neg ^ b_neg;
            neg_r_q   <= a_neg;
            opnd_q    <= Op[1] ? b_mag : a_mag;
            // Short ops enter RUN with cnt == 0 so they still take a FIX cycle.
            if (div_zero) begin
              raw_q <= 1'b1;
              dz_q  <= 1'b1;
              acc_q <= A;
              mq_q  <= '1;
              cnt_q <= '0;
            end else if (zero_skip) begin
              raw_q <= 1'b1;
              dz_q  <= 1'b0;
              acc_q <= '0;
              mq_q  <= '0;
              cnt_q <= '0;
            end else begin
              raw_q <= 1'b0;
              dz_q  <= 1'b0;
              acc_q <= '0;
              mq_q  <= Op[1] ? a_mag : b_mag;
              cnt_q <= CW'(WIDTH);
            end
          end else begin
            if (HiWrite) hi_q <= WData;
            if (LoWrite) lo_q <= WData;
          end
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            state_q <= S_FIX;
          end else begin
            cnt_q <= cnt_q - CW'(1);
            if (is_div_q) begin
              acc_q <= div_ge ? rem_sub : rem_sh[WIDTH-1:0];
              mq_q  <= {mq_q[WIDTH-2:0], div_ge};
            end else begin
              acc_q <= mul_sum[WIDTH:1];
              mq_q  <= {mul_sum[0], mq_q[WIDTH-1:1]};
            end
          end
        end
        S_FIX: begin
          hi_q      <= fix_hi_d;
          lo_q      <= fix_lo_d;
          divzero_q <= dz_q;
          done_q    <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit (WIDTH=32): arithmetic reference model
// compared every cycle, plus hand-computed directed expectations.
module tb_mult_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;
`ifdef MDU_ZERO_BYPASS_EN
  localparam int BYP_LAT = 2;
`else
  localparam int BYP_LAT = W + 2;
`endif

  logic         Clk = 1'b0;
  logic         Reset = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   Op = 2'b00;
  logic [W-1:0] A = '0, B = '0, WData = '0;
  logic         HiWrite = 1'b0, LoWrite = 1'b0;
  logic         Busy, Done, DivZero;
  logic [W-1:0] Hi, Lo;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .WData(WData),
    .Busy(Busy), .Done(Done), .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: result and latency (edges from Start sample to Done) from plain arithmetic.
  function automatic void ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] rh, output logic [W-1:0] rl,
                                 output bit dz, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    dz  = 1'b0;
    lat = W + 2;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (op)
      OP_MULT:  p = sa * sb;
      OP_MULTU: p = {32'b0, a} * {32'b0, b};
      default:  p = '0;
    endcase
    rh = p[63:32];
    rl = p[31:0];
    if (op[1]) begin
      if (b == '0) begin
        dz = 1'b1; rh = a; rl = '1; lat = 2;
      end else begin
        if (op == OP_DIVU) begin
          q = longint'({32'b0, a}) / longint'({32'b0, b});
          r = longint'({32'b0, a}) % longint'({32'b0, b});
        end else begin
          q = sa / sb;
          r = sa % sb;
        end
        rl = q[31:0];
        rh = r[31:0];
      end
    end
`ifdef MDU_ZERO_BYPASS_EN
    if ((op[1] && a == '0 && b != '0) || (!op[1] && (a == '0 || b == '0))) lat = 2;
`endif
  endfunction

  logic [W-1:0] m_hi = '0, m_lo = '0, r_hi, r_lo;
  bit m_busy = 0, m_done = 0, m_dz = 0, r_dz, m_active = 0;
  int m_j = 0, m_L = 0;

  always @(posedge Clk) begin
    if (!Reset) begin
      m_hi = '0; m_lo = '0; m_busy = 0; m_done = 0; m_dz = 0; m_active = 0;
    end else begin
      m_done = 0;
      if (m_active) begin
        m_j++;
        if (m_j == m_L) begin
          m_active = 0; m_busy = 0; m_done = 1;
          m_hi = r_hi; m_lo = r_lo; m_dz = r_dz;
        end else m_busy = 1;
      end else if (Start) begin
        ref_op(Op, A, B, r_hi, r_lo, r_dz, m_L);
        m_active = 1; m_j = 0; m_dz = 0;
      end else begin
        if (HiWrite) m_hi = WData;
        if (LoWrite) m_lo = WData;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("cyc_hi", Hi, m_hi);
      chk("cyc_lo", Lo, m_lo);
      chk("cyc_busy", Busy, m_busy);
      chk("cyc_done", Done, m_done);
      chk("cyc_divzero", DivZero, m_dz);
    end
  end

  // Called at a negedge; returns one cycle after the Start edge.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Returns at the negedge where Done is visible (the Done cycle).
  task automatic wait_done(output int lat, output int bc);
    lat = 0; bc = 0;
    while (!Done && lat < 200) begin
      if (Busy) bc++;
      @(negedge Clk);
      lat++;
    end
    if (lat >= 200) begin
      checks++; errors++;
      $display("FAIL done_timeout: actual=no Done required=Done within 200 cycles");
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int lat, output int bc);
    launch(op, a, b);
    wait_done(lat, bc);
  endtask

  typedef struct {logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b;} vec_t;
  vec_t vecs[6] = '{
    '{OP_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE},
    '{OP_DIV,  32'd7,        32'hFFFFFFFE},
    '{OP_MULT, 32'hFFFF0000, 32'hFFFF0001},
    '{OP_MULTU,32'h80000000, 32'h00000003},
    '{OP_DIVU, 32'hFFFFFFFF, 32'h00000010},
    '{OP_DIV,  32'h12345678, 32'h00000001}
  };

  initial begin
    int lat, bc;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk_en = 1'b1;
    chk("rst_hi", Hi, 0);
    chk("rst_lo", Lo, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_divzero", DivZero, 0);
    Reset = 1'b1;
    @(negedge Clk);

    do_op(OP_MULT, 32'hFFFFFFFD, 32'd7, lat, bc);
    chk("mult_lat", lat, 34);
    chk("mult_busy_cycles", bc, 33);
    chk("mult_hi", Hi, 32'hFFFFFFFF);
    chk("mult_lo", Lo, 32'hFFFFFFEB);

    do_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc);
    chk("multu_hi", Hi, 32'hFFFFFFFE);
    chk("multu_lo", Lo, 32'h00000001);

    do_op(OP_DIV, 32'hFFFFFFF9, 32'd2, lat, bc);
    chk("div_hi", Hi, 32'hFFFFFFFF);
    chk("div_lo", Lo, 32'hFFFFFFFD);

    do_op(OP_DIVU, 32'd7, 32'd2, lat, bc);
    chk("divu_hi", Hi, 32'd1);
    chk("divu_lo", Lo, 32'd3);

    do_op(OP_DIV, 32'd5, 32'd0, lat, bc);
    chk("dz_lat", lat, 2);
    chk("dz_busy_cycles", bc, 1);
    chk("dz_flag", DivZero, 1);
    chk("dz_hi", Hi, 32'd5);
    chk("dz_lo", Lo, 32'hFFFFFFFF);
    launch(OP_MULT, 32'd2, 32'd3);
    chk("dz_cleared", DivZero, 0);
    wait_done(lat, bc);
    chk("mult23_lo", Lo, 32'd6);

    do_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc);
    chk("ovf_hi", Hi, 32'h0);
    chk("ovf_lo", Lo, 32'h80000000);
    chk("ovf_flag", DivZero, 0);

    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
    chk("vec_last_lo", Lo, 32'h12345678);

    launch(OP_MULTU, 32'd1000, 32'd1000);
    repeat (10) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    chk("rst_run_busy", Busy, 0);
    chk("rst_run_done", Done, 0);
    chk("rst_run_hi", Hi, 0);
    chk("rst_run_lo", Lo, 0);
    repeat (40) @(negedge Clk);
    do_op(OP_MULTU, 32'd1000, 32'd1000, lat, bc);
    chk("retry_lat", lat, 34);
    chk("retry_lo", Lo, 32'd1000000);

    @(negedge Clk);
    HiWrite = 1'b1; WData = 32'h1234;
    @(negedge Clk);
    HiWrite = 1'b0;
    chk("mthi", Hi, 32'h1234);
    HiWrite = 1'b1; LoWrite = 1'b1; WData = 32'hA5A5;
    @(negedge Clk);
    HiWrite = 1'b0; LoWrite = 1'b0;
    chk("both_hi", Hi, 32'hA5A5);
    chk("both_lo", Lo, 32'hA5A5);

    launch(OP_MULT, 32'd9, 32'd9);
    HiWrite = 1'b1; WData = 32'hDEAD;
    repeat (3) @(negedge Clk);
    HiWrite = 1'b0;
    chk("busy_write_hi", Hi, 32'hA5A5);
    wait_done(lat, bc);
    chk("busy_write_res", Lo, 32'd81);

    Start = 1'b1; Op = OP_MULTU; A = 32'd3; B = 32'd4; HiWrite = 1'b1; WData = 32'h5555;
    @(negedge Clk);
    Start = 1'b0; HiWrite = 1'b0;
    chk("start_wins_hi", Hi, 32'h0);
    wait_done(lat, bc);
    chk("start_wins_lo", Lo, 32'd12);

    do_op(OP_MULT, 32'd0, 32'd5, lat, bc);
    chk("bypass_lat", lat, BYP_LAT);
    chk("bypass_hi", Hi, 0);
    chk("bypass_lo", Lo, 0);
    do_op(OP_DIVU, 32'd0, 32'd3, lat, bc);
    chk("bypass_div_lat", lat, BYP_LAT);

    repeat (3) @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=still running required=finished");
    $fatal(1, "timeout");
  end

endmodule
